// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Stall vector layout: bit0=PC, 1=IF, 2=ID, 3=EX, 4=MEM, 5=WB.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    MC_IDLE = 2'b00,
    MC_BUSY = 2'b01,
    MC_DONE = 2'b10
  } mc_state_t;

  localparam logic [5:0]  STALL_NONE = 6'b000000;
  // Load-use: hold PC/IF/ID, EX receives a bubble
  localparam logic [5:0]  STALL_ID   = 6'b000111;
  // Multicycle EX: hold everything up to and including EX
  localparam logic [5:0]  STALL_EX   = 6'b001111;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

endpackage

// File: rtl/pipe_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline; owns the
// multicycle-EX occupancy FSM and merges load-use stalls and redirects.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MC_CYCLES = 32,
  parameter int STALL_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_id,
  input  logic               ex_mc_start,
  input  logic               ex_mc_cancel,
  input  logic               flush_req,
  input  logic [31:0]        flush_pc,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic [31:0]        new_pc,
  output logic               mc_busy,
  output logic               mc_done
);

  localparam int              CNT_W    = $clog2(MC_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_CYCLES - 2);

  mc_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             mc_busy_reg;

  // cnt holds the busy cycles still to come after the current one; the
  // FSM enters MC_DONE as the loaded or decremented count reaches zero,
  // which places mc_done exactly MC_CYCLES-1 cycles after the start cycle.
  always_comb begin
    stall      = STALL_W'(STALL_NONE);
    flush      = 1'b0;
    new_pc     = ZERO_WORD;
    mc_done    = 1'b0;
    state_next = state_reg;
    cnt_next   = cnt_reg;

    if (flush_req) begin
      flush      = 1'b1;
      new_pc     = flush_pc;
      state_next = MC_IDLE;
      cnt_next   = '0;
    end else if (ex_mc_cancel && (state_reg != MC_IDLE)) begin
      state_next = MC_IDLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        MC_IDLE: begin
          if (ex_mc_start) begin
            stall      = STALL_W'(STALL_EX);
            cnt_next   = CNT_LOAD;
            state_next = (CNT_LOAD == '0) ? MC_DONE : MC_BUSY;
          end else if (stallreq_id) begin
            stall = STALL_W'(STALL_ID);
          end
        end
        MC_BUSY: begin
          stall    = STALL_W'(STALL_EX);
          cnt_next = cnt_reg - CNT_W'(1);
          if (cnt_reg <= CNT_W'(1)) begin
            state_next = MC_DONE;
            cnt_next   = '0;
          end
        end
        MC_DONE: begin
          mc_done    = 1'b1;
          state_next = MC_IDLE;
        end
        default: begin
          state_next = MC_IDLE;
          cnt_next   = '0;
        end
      endcase
    end

    // Outputs read as idle for as long as reset is held
    if (rst) begin
      stall   = STALL_W'(STALL_NONE);
      flush   = 1'b0;
      new_pc  = ZERO_WORD;
      mc_done = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= MC_IDLE;
      cnt_reg     <= '0;
      mc_busy_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      mc_busy_reg <= (state_next == MC_BUSY);
    end
  end

  assign mc_busy = mc_busy_reg;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl (MC_CYCLES=4): stimulus pushes expected
// outputs per cycle, a monitor pops and compares them at the falling edge.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_id;
  logic        ex_mc_start;
  logic        ex_mc_cancel;
  logic        flush_req;
  logic [31:0] flush_pc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        mc_busy;
  logic        mc_done;

  typedef struct packed {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        mc_busy;
    logic        mc_done;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  pipe_ctrl #(.MC_CYCLES(4), .STALL_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id  (stallreq_id),
    .ex_mc_start  (ex_mc_start),
    .ex_mc_cancel (ex_mc_cancel),
    .flush_req    (flush_req),
    .flush_pc     (flush_pc),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .mc_busy      (mc_busy),
    .mc_done      (mc_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: every cycle with a pending expectation is compared at negedge
  initial begin
    exp_t  e;
    exp_t  a;
    string t;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        a = '{stall: stall, flush: flush, new_pc: new_pc, mc_busy: mc_busy, mc_done: mc_done};
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL %s: got stall=%b flush=%b new_pc=%h busy=%b done=%b, want stall=%b flush=%b new_pc=%h busy=%b done=%b",
                   t, a.stall, a.flush, a.new_pc, a.mc_busy, a.mc_done,
                   e.stall, e.flush, e.new_pc, e.mc_busy, e.mc_done);
        end else begin
          $display("ok   %s: stall=%b flush=%b new_pc=%h busy=%b done=%b",
                   t, a.stall, a.flush, a.new_pc, a.mc_busy, a.mc_done);
        end
      end
    end
  end

  task automatic step(input string tag, input logic s, input logic c, input logic r,
                      input logic f, input logic [31:0] pc,
                      input logic [5:0] es, input logic ef, input logic [31:0] enp,
                      input logic eb, input logic ed);
    @(posedge clk);
    #1;
    ex_mc_start  = s;
    ex_mc_cancel = c;
    stallreq_id  = r;
    flush_req    = f;
    flush_pc     = pc;
    exp_q.push_back('{stall: es, flush: ef, new_pc: enp, mc_busy: eb, mc_done: ed});
    tag_q.push_back(tag);
  endtask

  // Asynchronous reset pulse spanning the sample point, released mid-cycle
  task automatic rst_cycle(input string tag);
    @(posedge clk);
    #1;
    rst          = 1'b1;
    ex_mc_start  = 1'b0;
    ex_mc_cancel = 1'b0;
    stallreq_id  = 1'b0;
    flush_req    = 1'b0;
    flush_pc     = 32'hDEAD_BEEF;
    exp_q.push_back('0);
    tag_q.push_back(tag);
    #6;
    rst = 1'b0;
  endtask

  // Watchdog so the run always ends with a summary
  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: got no end of stimulus, want completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    rst = 1'b1; stallreq_id = 0; ex_mc_start = 0; ex_mc_cancel = 0; flush_req = 0; flush_pc = '0;
    rst_cycle("reset0");
    rst_cycle("reset1");
    step("idle",          0,0,0,0,32'h0,        6'b000000,0,32'h0,0,0);

    // load-use stall for one cycle
    step("ld_use",        0,0,1,0,32'h0,        6'b000111,0,32'h0,0,0);
    step("ld_use_clr",    0,0,0,0,32'h0,        6'b000000,0,32'h0,0,0);

    // full multicycle op, start held through the done cycle
    step("mc_t0",         1,0,0,0,32'h0,        6'b001111,0,32'h0,0,0);
    step("mc_t1_sreq",    1,0,1,0,32'h0,        6'b001111,0,32'h0,1,0);
    step("mc_t2",         1,0,0,0,32'h0,        6'b001111,0,32'h0,1,0);
    step("mc_t3_done",    1,0,0,0,32'h0,        6'b000000,0,32'h0,0,1);
    step("mc_t4_idle",    0,0,0,0,32'h0,        6'b000000,0,32'h0,0,0);

    // flush in the last busy cycle: no done pulse afterwards
    step("fl_t0",         1,0,0,0,32'h0,        6'b001111,0,32'h0,0,0);
    step("fl_t1",         1,0,0,0,32'h0,        6'b001111,0,32'h0,1,0);
    step("fl_cnt1",       1,0,1,1,32'h0000_0100,6'b000000,1,32'h0000_0100,1,0);
    step("fl_after",      0,0,0,0,32'h0,        6'b000000,0,32'h0,0,0);
    step("fl_after2",     0,0,0,0,32'h0,        6'b000000,0,32'h0,0,0);

    // cancel with load-use in busy, load-use takes over next cycle
    step("cx_t0",         1,0,0,0,32'h0,        6'b001111,0,32'h0,0,0);
    step("cx_cancel",     1,1,1,0,32'h0,        6'b000000,0,32'h0,1,0);
    step("cx_sreq",       0,0,1,0,32'h0,        6'b000111,0,32'h0,0,0);
    step("cx_idle",       0,0,0,0,32'h0,        6'b000000,0,32'h0,0,0);

    // cancel in IDLE is inert; cancel in MC_DONE suppresses the pulse
    step("cx_in_idle",    0,1,1,0,32'h0,        6'b000111,0,32'h0,0,0);
    step("cd_t0",         1,0,0,0,32'h0,        6'b001111,0,32'h0,0,0);
    step("cd_t1",         1,0,0,0,32'h0,        6'b001111,0,32'h0,1,0);
    step("cd_t2",         1,0,0,0,32'h0,        6'b001111,0,32'h0,1,0);
    step("cd_cancel",     1,1,0,0,32'h0,        6'b000000,0,32'h0,0,0);
    step("cd_idle",       0,0,0,0,32'h0,        6'b000000,0,32'h0,0,0);

    // back-to-back ops, start re-raised right after mc_done
    step("bb_a0",         1,0,0,0,32'h0,        6'b001111,0,32'h0,0,0);
    step("bb_a1",         1,0,0,0,32'h0,        6'b001111,0,32'h0,1,0);
    step("bb_a2",         1,0,0,0,32'h0,        6'b001111,0,32'h0,1,0);
    step("bb_a_done",     1,0,0,0,32'h0,        6'b000000,0,32'h0,0,1);
    step("bb_b0",         1,0,0,0,32'h0,        6'b001111,0,32'h0,0,0);
    step("bb_b1",         1,0,0,0,32'h0,        6'b001111,0,32'h0,1,0);
    step("bb_b2",         1,0,0,0,32'h0,        6'b001111,0,32'h0,1,0);
    step("bb_b_done",     0,0,0,0,32'h0,        6'b000000,0,32'h0,0,1);
    step("bb_idle",       0,0,0,0,32'h0,        6'b000000,0,32'h0,0,0);

    // flush in IDLE over a load-use request, and in MC_DONE over the pulse
    step("fl_idle",       0,0,1,1,32'hBFC0_0380,6'b000000,1,32'hBFC0_0380,0,0);
    step("fd_t0",         1,0,0,0,32'h0,        6'b001111,0,32'h0,0,0);
    step("fd_t1",         1,0,0,0,32'h0,        6'b001111,0,32'h0,1,0);
    step("fd_t2",         1,0,0,0,32'h0,        6'b001111,0,32'h0,1,0);
    step("fd_flush",      1,1,0,1,32'h8000_0180,6'b000000,1,32'h8000_0180,0,0);
    step("fd_idle",       0,0,0,0,32'h0,        6'b000000,0,32'h0,0,0);

    // async reset in the middle of an op drops it silently
    step("rm_t0",         1,0,0,0,32'h0,        6'b001111,0,32'h0,0,0);
    step("rm_t1",         1,0,0,0,32'h0,        6'b001111,0,32'h0,1,0);
    rst_cycle("rm_reset");
    step("rm_after",      0,0,0,0,32'h0,        6'b000000,0,32'h0,0,0);
    step("rm_after2",     0,0,0,0,32'h0,        6'b000000,0,32'h0,0,0);

    @(posedge clk);
    @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
